mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus among NUM_CLIENTS cache clients.
//
// Each cycle one eligible client is selected. Its command and address drive
// the memory bus combinationally. The request is granted when memory answers
// with a nonzero tag on mem2proc_response. Load tags are recorded in a
// 16-entry owner table, so data returning on mem2proc_tag can be routed back
// to the client that issued the load. Per-client outstanding counters
// throttle loads at MAX_OUTSTANDING.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   client_command/addr       per-client request (BUS_NONE = idle)
//   client_grant/_grant_tag   one-hot accept strobe and the tag memory gave it
//   proc2mem_command/addr     request presented to memory
//   mem2proc_response         nonzero = tag granted for the presented request
//   mem2proc_data/tag         returning load data and its tag (0 = none)
//   resp_valid/data/tag       returned data routed to its owning client
//   orphan_tag                returning tag has no owner in the table
//
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority selection
// (highest index wins, no round-robin pointer). The default build is
// round-robin.

package mem_arbiter_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_command_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  bus_command_t [NUM_CLIENTS-1:0]    client_command,
  input  logic [NUM_CLIENTS-1:0][XLEN-1:0]  client_addr,
  output logic [NUM_CLIENTS-1:0]            client_grant,
  output logic [3:0]                        client_grant_tag,
  output bus_command_t                      proc2mem_command,
  output logic [XLEN-1:0]                   proc2mem_addr,
  input  logic [3:0]                        mem2proc_response,
  input  logic [63:0]                       mem2proc_data,
  input  logic [3:0]                        mem2proc_tag,
  output logic [NUM_CLIENTS-1:0]            resp_valid,
  output logic [63:0]                       resp_data,
  output logic [3:0]                        resp_tag,
  output logic                              orphan_tag
);

  localparam int         IDX_W   = $clog2(NUM_CLIENTS);
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef logic [IDX_W-1:0] idx_t;

  logic [15:0]            tag_valid;
  idx_t                   tag_owner [16];
  logic [NUM_CLIENTS-1:0] eligible;
  logic                   sel_valid;
  idx_t                   sel_idx;
  logic                   grant;
  logic                   load_grant;
  logic                   resp_hit;
  idx_t                   resp_owner;

  // Tag table. A return clears its entry first; a load grant naming the same
  // tag in that cycle is written after it, so the new allocation survives.
  // NOTE: state registers use non-blocking (<=) so every always_ff reads the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
    end else begin
      if (resp_hit)   tag_valid[mem2proc_tag]      <= 1'b0;
      if (load_grant) tag_valid[mem2proc_response] <= 1'b1;
    end
  end

  // NOTE: the owner field is meaningless while its valid bit is clear, so this
  // storage array is deliberately left without reset.
  always_ff @(posedge clock) begin
    if (load_grant) tag_owner[mem2proc_response] <= sel_idx;
  end

  // Per-client outstanding-load counter and eligibility. The counter saturates
  // at both ends so a protocol error can never make it wrap.
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    logic [3:0] count;
    logic       inc;
    logic       dec;

    assign inc = load_grant && (sel_idx == idx_t'(i)) && (count != 4'hF);
    assign dec = resp_valid[i] && (count != 4'h0);

    always_ff @(posedge clock) begin
      if (reset)            count <= '0;
      else if (inc && !dec) count <= count + 4'd1;
      else if (dec && !inc) count <= count - 4'd1;
    end

    assign eligible[i] = (client_command[i] != BUS_NONE) &&
                         ((client_command[i] != BUS_LOAD) || (count < MAX_CNT));
  end

  // NOTE: each combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned (no inferred latch).
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (!sel_valid && eligible[idx_t'(i)]) begin
        sel_valid = 1'b1;
        sel_idx   = idx_t'(i);
      end
    end
  end
`else
  idx_t rr_ptr;

  // Search upward from rr_ptr with wrap-around; the first eligible client wins.
  always_comb begin
    int idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!sel_valid && eligible[idx_t'(idx)]) begin
        sel_valid = 1'b1;
        sel_idx   = idx_t'(idx);
      end
    end
  end

  // The pointer moves only on an accepted request, so a stalled client keeps
  // being presented until memory takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (sel_idx == idx_t'(NUM_CLIENTS - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`endif

  assign grant      = !reset && sel_valid && (mem2proc_response != 4'd0);
  assign load_grant = grant && (client_command[sel_idx] == BUS_LOAD);

  // The table is read with its registered contents, so a same-cycle grant of
  // the returning tag does not affect where this response is routed.
  assign resp_hit   = !reset && (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];
  assign orphan_tag = !reset && (mem2proc_tag != 4'd0) && !tag_valid[mem2proc_tag];
  assign resp_owner = tag_owner[mem2proc_tag];

  always_comb begin
    client_grant = '0;
    resp_valid   = '0;
    if (grant)    client_grant[sel_idx]  = 1'b1;
    if (resp_hit) resp_valid[resp_owner] = 1'b1;
  end

  assign client_grant_tag = grant ? mem2proc_response : 4'd0;
  assign proc2mem_command = (!reset && sel_valid) ? client_command[sel_idx] : BUS_NONE;
  assign proc2mem_addr    = (!reset && sel_valid) ? client_addr[sel_idx] : '0;
  assign resp_data        = resp_hit ? mem2proc_data : 64'd0;
  assign resp_tag         = resp_hit ? mem2proc_tag : 4'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter (NUM_CLIENTS=2, MAX_OUTSTANDING=2).
// The driver applies one cycle of inputs at each falling edge and pushes the
// outputs a reference model expects into per-kind queues. The monitor samples
// the DUT shortly after each falling edge and pops/compares whenever either
// the DUT shows an output or an expectation is due for that cycle.
// The reference model keeps a tag->owner map; a client's outstanding count is
// simply the number of map entries it owns.

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int MAX = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  bus_command_t [N-1:0]    client_command;
  logic [N-1:0][XLEN-1:0]  client_addr;
  logic [N-1:0]            client_grant;
  logic [3:0]              client_grant_tag;
  bus_command_t            proc2mem_command;
  logic [XLEN-1:0]         proc2mem_addr;
  logic [3:0]              mem2proc_response;
  logic [63:0]             mem2proc_data;
  logic [3:0]              mem2proc_tag;
  logic [N-1:0]            resp_valid;
  logic [63:0]             resp_data;
  logic [3:0]              resp_tag;
  logic                    orphan_tag;

  always #5 clock = ~clock;

  mem_arbiter #(
    .NUM_CLIENTS     (N),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .client_command    (client_command),
    .client_addr       (client_addr),
    .client_grant      (client_grant),
    .client_grant_tag  (client_grant_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .resp_valid        (resp_valid),
    .resp_data         (resp_data),
    .resp_tag          (resp_tag),
    .orphan_tag        (orphan_tag)
  );

  typedef struct {
    int              cyc;
    int              client;
    bus_command_t    cmd;
    logic [XLEN-1:0] addr;
    logic [3:0]      tag;
    logic [63:0]     data;
  } ev_t;

  ev_t bus_q[$];
  ev_t grant_q[$];
  ev_t resp_q[$];
  ev_t orphan_q[$];

  int              owner_of [16];
  int              rr_model;
  int              drv_cyc;
  int              mon_cyc;
  int              n_cmp;
  int              n_bad;
  bit              mon_on;
  bus_command_t    drv_cmd  [N];
  logic [XLEN-1:0] drv_addr [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: actual %0h expected %0h", name, mon_cyc, act, exp);
    end
  endtask

  function automatic int inflight(input int c);
    int n;
    n = 0;
    for (int t = 1; t < 16; t++) if (owner_of[t] == c) n++;
    return n;
  endfunction

  function automatic bit eligible_m(input int c);
    return (drv_cmd[c] != BUS_NONE) && ((drv_cmd[c] != BUS_LOAD) || (inflight(c) < MAX));
  endfunction

  task automatic cmds(input bus_command_t c0, input bus_command_t c1);
    drv_cmd[0]  = c0;
    drv_cmd[1]  = c1;
    drv_addr[0] = $urandom;
    drv_addr[1] = $urandom;
  endtask

  // One clock cycle: apply inputs, predict outputs, advance the model.
  task automatic step(input logic rst, input logic [3:0] rsp, input logic [3:0] rtag,
                      input logic [63:0] data);
    ev_t e;
    int  sel;
    int  ret_owner;
    int  c;
    @(negedge clock);
    reset             = rst;
    mem2proc_response = rsp;
    mem2proc_tag      = rtag;
    mem2proc_data     = data;
    for (int i = 0; i < N; i++) begin
      client_command[i] = drv_cmd[i];
      client_addr[i]    = drv_addr[i];
    end
    if (rst) begin
      for (int t = 0; t < 16; t++) owner_of[t] = -1;
      rr_model = 0;
    end else begin
      ret_owner = -1;
      if (rtag != 4'd0) begin
        ret_owner = owner_of[rtag];
        e = '{cyc: drv_cyc, client: ret_owner, cmd: BUS_NONE, addr: '0, tag: rtag, data: data};
        if (ret_owner >= 0) resp_q.push_back(e);
        else                orphan_q.push_back(e);
      end
      sel = -1;
      for (int k = 0; k < N; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        c = N - 1 - k;
`else
        c = (rr_model + k) % N;
`endif
        if (sel < 0 && eligible_m(c)) sel = c;
      end
      if (sel >= 0) begin
        e = '{cyc: drv_cyc, client: sel, cmd: drv_cmd[sel], addr: drv_addr[sel], tag: rsp, data: '0};
        bus_q.push_back(e);
        if (rsp != 4'd0) begin
          grant_q.push_back(e);
          rr_model = (sel + 1) % N;
        end
      end
      if (ret_owner >= 0) owner_of[rtag] = -1;
      if (sel >= 0 && rsp != 4'd0 && drv_cmd[sel] == BUS_LOAD) owner_of[rsp] = sel;
    end
    drv_cyc++;
  endtask

  // Monitor: decoupled from the driver, matched by cycle stamp.
  initial begin
    ev_t e;
    bit  exp;
    bit  act;
    forever begin
      @(negedge clock);
      #2;
      if (mon_on) begin
        exp = (bus_q.size() > 0) && (bus_q[0].cyc == mon_cyc);
        act = (proc2mem_command != BUS_NONE) || (proc2mem_addr != '0);
        if (exp || act) begin
          check("bus_present", 64'(act), 64'(exp));
          if (exp) begin
            e = bus_q.pop_front();
            if (act) begin
              check("bus_cmd", 64'(proc2mem_command), 64'(e.cmd));
              check("bus_addr", 64'(proc2mem_addr), 64'(e.addr));
            end
          end
        end

        exp = (grant_q.size() > 0) && (grant_q[0].cyc == mon_cyc);
        act = (client_grant != '0) || (client_grant_tag != 4'd0);
        if (exp || act) begin
          check("grant_present", 64'(act), 64'(exp));
          if (exp) begin
            e = grant_q.pop_front();
            if (act) begin
              check("grant_onehot", 64'(client_grant), 64'(1) << e.client);
              check("grant_tag", 64'(client_grant_tag), 64'(e.tag));
            end
          end
        end

        exp = (resp_q.size() > 0) && (resp_q[0].cyc == mon_cyc);
        act = (resp_valid != '0) || (resp_data != 64'd0) || (resp_tag != 4'd0);
        if (exp || act) begin
          check("resp_present", 64'(act), 64'(exp));
          if (exp) begin
            e = resp_q.pop_front();
            if (act) begin
              check("resp_valid", 64'(resp_valid), 64'(1) << e.client);
              check("resp_data", resp_data, e.data);
              check("resp_tag", 64'(resp_tag), 64'(e.tag));
            end
          end
        end

        exp = (orphan_q.size() > 0) && (orphan_q[0].cyc == mon_cyc);
        act = orphan_tag;
        if (exp || act) begin
          check("orphan_present", 64'(act), 64'(exp));
          if (exp) e = orphan_q.pop_front();
        end
      end
      mon_cyc++;
    end
  end

  initial begin
    int       r;
    int       t;
    logic     rst;
    logic [3:0] rsp;
    logic [3:0] rtag;

    n_cmp             = 0;
    n_bad             = 0;
    drv_cyc           = 0;
    mon_cyc           = 0;
    mon_on            = 1'b1;
    rr_model          = 0;
    reset             = 1'b1;
    mem2proc_response = '0;
    mem2proc_tag      = '0;
    mem2proc_data     = '0;
    client_command    = '0;
    client_addr       = '0;
    for (int i = 0; i < 16; i++) owner_of[i] = -1;

    // Reset with active requests and returns: everything must stay quiet.
    cmds(BUS_LOAD, BUS_STORE);
    step(1'b1, 4'd3, 4'd5, 64'h1234);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b1, 4'd0, 4'd0, 64'd0);

    // Both clients load continuously, memory grants tags 1..4.
    cmds(BUS_LOAD, BUS_LOAD);
    for (int i = 1; i <= 4; i++) step(1'b0, 4'(i), 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_NONE);
    for (int i = 1; i <= 4; i++) step(1'b0, 4'd0, 4'(i), {$urandom, $urandom});

    // Client 1 stalled three cycles, then granted tag 5.
    cmds(BUS_NONE, BUS_LOAD);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 64'd0);
    step(1'b0, 4'd5, 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b0, 4'd0, 4'd5, {$urandom, $urandom});

    // Load tag 7 for client 0, data returns later.
    cmds(BUS_LOAD, BUS_NONE);
    step(1'b0, 4'd7, 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b0, 4'd0, 4'd0, 64'd0);
    step(1'b0, 4'd0, 4'd7, 64'hDEAD_BEEF);
    step(1'b0, 4'd0, 4'd7, 64'h5555);

    // Outstanding limit: third load held off until a slot is freed.
    cmds(BUS_LOAD, BUS_NONE);
    step(1'b0, 4'd1, 4'd0, 64'd0);
    step(1'b0, 4'd2, 4'd0, 64'd0);
    step(1'b0, 4'd3, 4'd0, 64'd0);
    step(1'b0, 4'd3, 4'd1, {$urandom, $urandom});
    step(1'b0, 4'd3, 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b0, 4'd0, 4'd2, {$urandom, $urandom});
    step(1'b0, 4'd0, 4'd3, {$urandom, $urandom});

    // Orphan return, then a store that must not allocate its tag.
    step(1'b0, 4'd0, 4'd9, 64'h99);
    cmds(BUS_NONE, BUS_STORE);
    step(1'b0, 4'd3, 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b0, 4'd0, 4'd3, 64'h33);

    // Same tag returned and re-granted in one cycle.
    cmds(BUS_LOAD, BUS_NONE);
    step(1'b0, 4'd6, 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_LOAD);
    step(1'b0, 4'd6, 4'd6, 64'h6666);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b0, 4'd0, 4'd6, 64'h7777);

    // Reset with tags 2 and 4 in flight; their returns become orphans.
    cmds(BUS_LOAD, BUS_LOAD);
    step(1'b0, 4'd2, 4'd0, 64'd0);
    step(1'b0, 4'd4, 4'd0, 64'd0);
    cmds(BUS_NONE, BUS_NONE);
    step(1'b1, 4'd0, 4'd0, 64'd0);
    step(1'b0, 4'd0, 4'd2, 64'h22);
    step(1'b0, 4'd0, 4'd4, 64'h44);

    // Randomized traffic. Memory never reuses a tag still in flight, except
    // the one returning in the same cycle.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        if (r < 3)      drv_cmd[i] = BUS_NONE;
        else if (r < 8) drv_cmd[i] = BUS_LOAD;
        else            drv_cmd[i] = BUS_STORE;
        drv_addr[i] = $urandom;
      end
      rtag = 4'd0;
      r = $urandom_range(0, 99);
      for (int k = 0; k < 20; k++) begin
        t = $urandom_range(1, 15);
        if (rtag == 4'd0) begin
          if (r < 45 && owner_of[t] >= 0) rtag = 4'(t);
          else if (r >= 45 && r < 50 && owner_of[t] < 0) rtag = 4'(t);
        end
      end
      rsp = 4'd0;
      if ($urandom_range(0, 99) < 70) begin
        for (int k = 0; k < 20; k++) begin
          t = $urandom_range(1, 15);
          if (rsp == 4'd0 && (owner_of[t] < 0 || 4'(t) == rtag)) rsp = 4'(t);
        end
      end
      step(rst, rsp, rtag, {$urandom, $urandom});
    end

    cmds(BUS_NONE, BUS_NONE);
    step(1'b0, 4'd0, 4'd0, 64'd0);
    #4;
    mon_on = 1'b0;
    check("queues_drained", 64'(bus_q.size() + grant_q.size() + resp_q.size() + orphan_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
